dual_port_mem: RTL and testbench

Parametrised single-clock, true-dual-port word memory for the pipelined core. Port A is the read-only instruction-fetch port and port B is the byte-enabled load/store port. It replaces the fixed 2-cycle simulation memory with configurable read latency, a selectable write mode, same-address collision bypass, an out-of-range guard and read-valid strobes. The memory array is not reset; all pipeline and valid state is.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_read_pipe.sv | 35 +++
 rtl/dual_port_mem.sv | 98 +++++++++
 tb/tb_dual_port_mem.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port word memory.
package mem_pkg;

    typedef enum logic {
        WM_READ_FIRST,
        WM_WRITE_FIRST
    } write_mode_e;

    // The merge works at a fixed maximum width. Callers widen their operands and narrow the result
    // to their own DATA_W.
    localparam int unsigned MaxDataW = 256;
    localparam int unsigned MaxBeW   = MaxDataW / 8;

    function automatic logic [MaxDataW-1:0] byte_merge(input logic [MaxDataW-1:0] old_w,
                                                       input logic [MaxDataW-1:0] new_w,
                                                       input logic [MaxBeW-1:0]   be);
        logic [MaxDataW-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MaxBeW); i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Read-result delay line: LAT stages of valid plus data. Data stages load only on valid, so the
// output holds the last result.
module mem_read_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]    valid_q;
    logic [DATA_W-1:0] data_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LAT); i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) data_q[0] <= data_i;
            for (int i = 1; i < int'(LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/dual_port_mem.sv
// Single-clock true-dual-port word memory: port A read-only fetch, port B byte-enabled load/store,
// with configurable read latency, write mode, collision bypass and an out-of-range guard.
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 16384,
    parameter int unsigned READ_LAT   = 2,
    parameter write_mode_e WRITE_MODE = WM_READ_FIRST,
    parameter bit          A_BYPASS   = 1'b1,
    parameter string       INIT_FILE  = "",
    parameter int unsigned SHOW_ADDR  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    output logic [DATA_W-1:0]        a_rdata,
    output logic                     a_rvalid,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [DATA_W/8-1:0]      b_be,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic [DATA_W-1:0]        b_rdata,
    output logic                     b_rvalid,
    output logic [DATA_W-1:0]        show_data
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DepthW  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ShowIdx = AW'(SHOW_ADDR);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("dual_port_mem: READ_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MaxDataW) begin : g_bad_width
        $error("dual_port_mem: DATA_W must be a multiple of 8 and at most MaxDataW");
    end
    if (SHOW_ADDR >= DEPTH) begin : g_bad_show
        $error("dual_port_mem: SHOW_ADDR out of range");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_in_range, b_in_range, b_wr_en, collide;
    logic [DATA_W-1:0] a_old, b_old, b_merged, a_word, b_word;

    always_comb begin
        a_in_range = {1'b0, a_addr} < DepthW;
        b_in_range = {1'b0, b_addr} < DepthW;
        // A write presented during reset must not touch the array.
        b_wr_en    = b_req & b_we & b_in_range & ~rst;
        a_old      = a_in_range ? mem[a_addr] : '0;
        b_old      = b_in_range ? mem[b_addr] : '0;
        b_merged   = DATA_W'(byte_merge(MaxDataW'(b_old), MaxDataW'(b_wdata), MaxBeW'(b_be)));
        collide    = a_req & b_wr_en & (a_addr == b_addr);
        a_word     = (A_BYPASS && collide) ? b_merged : a_old;
        if (!b_in_range) begin
            b_word = '0;
        end else if (b_we && WRITE_MODE == WM_WRITE_FIRST) begin
            b_word = b_merged;
        end else begin
            b_word = b_old;
        end
    end

    always_ff @(posedge clk) begin
        if (b_wr_en) mem[b_addr] <= b_merged;
    end

    assign show_data = mem[ShowIdx];

    mem_read_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_a_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (a_req),
        .data_i  (a_word),
        .valid_o (a_rvalid),
        .data_o  (a_rdata)
    );

    mem_read_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_b_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (b_req),
        .data_i  (b_word),
        .valid_o (b_rvalid),
        .data_o  (b_rdata)
    );

endmodule

// File: tb/tb_dual_port_mem.sv
// Bench for dual_port_mem: two instances sharing stimulus (u0: defaults, READ_LAT 2, read-first,
// bypass; u1: DEPTH 12, READ_LAT 1, write-first, no bypass).
module tb_dual_port_mem;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, b_req, b_we;
    logic [3:0]  a_addr, b_addr, b_be;
    logic [31:0] b_wdata;

    logic [31:0] a_rdata0, b_rdata0, show0, a_rdata1, b_rdata1, show1;
    logic        a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_mem u0 (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_addr    ({10'd0, a_addr}),
        .a_rdata   (a_rdata0),
        .a_rvalid  (a_rvalid0),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_be      (b_be),
        .b_addr    ({10'd0, b_addr}),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata0),
        .b_rvalid  (b_rvalid0),
        .show_data (show0)
    );

    dual_port_mem #(
        .DEPTH      (12),
        .READ_LAT   (1),
        .WRITE_MODE (WM_WRITE_FIRST),
        .A_BYPASS   (1'b0)
    ) u1 (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata1),
        .a_rvalid  (a_rvalid1),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_be      (b_be),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata1),
        .b_rvalid  (b_rvalid1),
        .show_data (show1)
    );

    typedef struct {
        logic        ar;
        logic [3:0]  aa;
        logic        br;
        logic        bwe;
        logic [3:0]  bbe;
        logic [3:0]  ba;
        logic [31:0] bwd;
        logic [31:0] ea0, eb0, ea1, eb1;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0;
        b_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " a_rvalid0"}, 32'(a_rvalid0), 32'd0);
        check({tag, " b_rvalid0"}, 32'(b_rvalid0), 32'd0);
        check({tag, " a_rvalid1"}, 32'(a_rvalid1), 32'd0);
        check({tag, " b_rvalid1"}, 32'(b_rvalid1), 32'd0);
        check({tag, " a_rdata0"}, a_rdata0, 32'd0);
        check({tag, " b_rdata0"}, b_rdata0, 32'd0);
        check({tag, " a_rdata1"}, a_rdata1, 32'd0);
        check({tag, " b_rdata1"}, b_rdata1, 32'd0);
    endtask

    // One request cycle, then u1's result (lat 1) and u0's result (lat 2) are checked in turn.
    task automatic apply(input vec_t v, input string tag);
        a_req = v.ar; a_addr = v.aa; b_req = v.br; b_we = v.bwe; b_be = v.bbe; b_addr = v.ba;
        b_wdata = v.bwd;
        @(posedge clk); #1;
        idle();
        check({tag, " a_rvalid1"}, 32'(a_rvalid1), 32'(v.ar));
        check({tag, " b_rvalid1"}, 32'(b_rvalid1), 32'(v.br));
        if (v.ar) check({tag, " a_rdata1"}, a_rdata1, v.ea1);
        if (v.br) check({tag, " b_rdata1"}, b_rdata1, v.eb1);
        @(posedge clk); #1;
        check({tag, " a_rvalid0"}, 32'(a_rvalid0), 32'(v.ar));
        check({tag, " b_rvalid0"}, 32'(b_rvalid0), 32'(v.br));
        if (v.ar) check({tag, " a_rdata0"}, a_rdata0, v.ea0);
        if (v.br) check({tag, " b_rdata0"}, b_rdata0, v.eb0);
        check({tag, " a_rvalid1 pulse"}, 32'(a_rvalid1), 32'd0);
        check({tag, " b_rvalid1 pulse"}, 32'(b_rvalid1), 32'd0);
        if (v.ar) check({tag, " a_rdata1 hold"}, a_rdata1, v.ea1);
    endtask

    logic [31:0] tp_exp [8];
    vec_t        vr;

    initial begin
        //          ar    aa    br    bwe   bbe    ba     bwd            ea0/eb0/ea1/eb1
        vecs[0]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'hF, 4'd5, 32'h11223344,
                     32'h0, 32'hC0DE0005, 32'h0, 32'h11223344};
        vecs[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABBCCDD,
                     32'h0, 32'h11223344, 32'h0, 32'h11BB33DD};
        vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0,
                     32'h0, 32'h11BB33DD, 32'h0, 32'h11BB33DD};
        vecs[3]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0,
                     32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h0};
        vecs[4]  = '{1'b1, 4'd9, 1'b1, 1'b1, 4'hF, 4'd9, 32'hDEADBEEF,
                     32'hDEADBEEF, 32'hC0DE0009, 32'hC0DE0009, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 4'd9, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 4'd12, 1'b1, 1'b1, 4'hF, 4'd13, 32'h12345678,
                     32'hC0DE000C, 32'hC0DE000D, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 4'd13, 1'b1, 1'b0, 4'h0, 4'd13, 32'h0,
                     32'h12345678, 32'h12345678, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0,
                     32'hC0DE0001, 32'h0, 32'hC0DE0001, 32'h0};
        vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'h0, 4'd6, 32'hFFFFFFFF,
                     32'h0, 32'hC0DE0006, 32'h0, 32'hC0DE0006};
        vecs[10] = '{1'b1, 4'd6, 1'b1, 1'b0, 4'h0, 4'd6, 32'h0,
                     32'hC0DE0006, 32'hC0DE0006, 32'hC0DE0006, 32'hC0DE0006};
        vecs[11] = '{1'b1, 4'd3, 1'b1, 1'b1, 4'b1000, 4'd3, 32'h7F000000,
                     32'h7FDE0003, 32'hC0DE0003, 32'hC0DE0003, 32'h7FDE0003};

        tp_exp = '{32'hC0DE0000, 32'h000000FF, 32'hC0DE0002, 32'h7FDE0003,
                   32'hC0DE0004, 32'h11BB33DD, 32'hC0DE0006, 32'hC0DE0007};

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Preload 0..13; u1 drops 12 and 13 as out of range.
        for (int i = 0; i < 14; i++) begin
            b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 4'(i);
            b_wdata = 32'hC0DE0000 + 32'(i);
            @(posedge clk); #1;
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("show0 preload", show0, 32'hC0DE0001);
        check("show1 preload", show1, 32'hC0DE0001);

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Debug mirror follows a write right after its edge; next-cycle read sees the new word.
        b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 4'd1; b_wdata = 32'h000000FF;
        @(posedge clk); #1;
        idle();
        check("show0 after write", show0, 32'h000000FF);
        check("show1 after write", show1, 32'h000000FF);
        a_req = 1'b1; a_addr = 4'd1;
        @(posedge clk); #1;
        idle();
        check("raw a_rdata1", a_rdata1, 32'h000000FF);
        @(posedge clk); #1;
        check("raw a_rdata0", a_rdata0, 32'h000000FF);
        repeat (2) @(posedge clk);
        #1;

        // Eight back-to-back port A reads.
        for (int c = 0; c < 11; c++) begin
            a_req = (c < 8); a_addr = 4'(c);
            @(posedge clk); #1;
            check($sformatf("tp%0d a_rvalid1", c), 32'(a_rvalid1), 32'(c < 8));
            if (c < 8) check($sformatf("tp%0d a_rdata1", c), a_rdata1, tp_exp[c]);
            check($sformatf("tp%0d a_rvalid0", c), 32'(a_rvalid0), 32'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) check($sformatf("tp%0d a_rdata0", c), a_rdata0, tp_exp[c-1]);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset with reads in flight and a write presented during reset.
        a_req = 1'b1; a_addr = 4'd5; b_req = 1'b1; b_addr = 4'd9;
        @(posedge clk); #1;
        idle();
        check("pre-rst a_rvalid1", 32'(a_rvalid1), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("in rst");
        b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 4'd2; b_wdata = 32'h0BAD0BAD;
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post rst 1");
        @(posedge clk); #1;
        check_all_zero("post rst 2");
        vr = '{1'b1, 4'd2, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0,
               32'hC0DE0002, 32'h11BB33DD, 32'hC0DE0002, 32'h11BB33DD};
        apply(vr, "after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
